// File: rtl/core_arb_pkg.sv
// Shared types and helpers for the core data-port arbiter: ID width and the
// wrap-around first-set search used for requester selection.
package core_arb_pkg;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } pick_t;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set bit of req[n-1:0], scanning upward from ptr and wrapping at n.
    function automatic pick_t rr_pick(input logic [7:0] req, input int ptr, input int n);
        pick_t r;
        int    c;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < n && !r.valid) begin
                c = (ptr + i) % n;
                if (req[c]) begin
                    r.valid = 1'b1;
                    r.idx   = 3'(c);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/core_arb_id_fifo.sv
// In-order FIFO of granted requester IDs. Push and pop in the same cycle are
// accepted even when full; the head read this cycle is the entry being popped.
module core_arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/core_data_arbiter.sv
// Shares one req/gnt/rvalid data port between NUM_REQ requesters with locked
// round-robin selection; CORE_ARB_FIXED_PRIO_EN selects fixed priority instead.
module core_data_arbiter
    import core_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            m_req_i,
    output logic [NUM_REQ-1:0]            m_gnt_o,
    output logic [NUM_REQ-1:0]            m_rvalid_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_REQ-1:0]            m_we_i,
    input  logic [NUM_REQ*4-1:0]          m_be_i,
    input  logic [NUM_REQ*32-1:0]         m_wdata_i,
    output logic [31:0]                   m_rdata_o,
    output logic                          s_req_o,
    input  logic                          s_gnt_i,
    input  logic                          s_rvalid_i,
    output logic [ADDR_WIDTH-1:0]         s_addr_o,
    output logic                          s_we_o,
    output logic [3:0]                    s_be_o,
    output logic [31:0]                   s_wdata_o,
    input  logic [31:0]                   s_rdata_i,
    output logic                          protocol_err_o
);

    localparam int IDW = id_width(NUM_REQ);

    logic           r_lock_q;
    logic [IDW-1:0] r_sel_q;
    logic [IDW-1:0] w_sel;
    pick_t          w_pick;
    logic           w_grant;
    logic           w_full;
    logic           w_empty;
    logic [IDW-1:0] w_head;

`ifdef CORE_ARB_FIXED_PRIO_EN
    assign w_pick = rr_pick(8'(m_req_i), 0, NUM_REQ);
`else
    logic [IDW-1:0] r_rr_ptr_q;

    assign w_pick = rr_pick(8'(m_req_i), int'(r_rr_ptr_q), NUM_REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr_q <= '0;
        end else if (w_grant) begin
            r_rr_ptr_q <= (w_sel == IDW'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
        end
    end
`endif

    assign w_sel   = r_lock_q ? r_sel_q : w_pick.idx[IDW-1:0];
    // A locked request was accepted while not full, so it must stay visible.
    assign s_req_o = m_req_i[w_sel] & (r_lock_q | (w_pick.valid & ~w_full));
    assign w_grant = s_req_o & s_gnt_i;

    assign s_addr_o  = m_addr_i[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_we_o    = m_we_i[w_sel];
    assign s_be_o    = m_be_i[int'(w_sel)*4 +: 4];
    assign s_wdata_o = m_wdata_i[int'(w_sel)*32 +: 32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_q <= 1'b0;
            r_sel_q  <= '0;
        end else if (w_grant) begin
            r_lock_q <= 1'b0;
        end else if (s_req_o) begin
            r_lock_q <= 1'b1;
            r_sel_q  <= w_sel;
        end else begin
            // Either nothing pending or the locked requester abandoned its request.
            r_lock_q <= 1'b0;
        end
    end

    core_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDW)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_grant),
        .i_data  (w_sel),
        .i_pop   (s_rvalid_i),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        if (w_grant) m_gnt_o[w_sel] = 1'b1;
        if (s_rvalid_i && !w_empty) m_rvalid_o[w_head] = 1'b1;
    end

    assign m_rdata_o      = s_rdata_i;
    assign protocol_err_o = s_rvalid_i & w_empty;

endmodule
